// File: rtl/queen_stack.sv
// LIFO of (row, col) placements for the N-queens backtracking datapath.
// Optional max_depth watermark output enabled by defining QUEEN_STACK_WATERMARK_EN.
module queen_stack #(
    parameter int unsigned N_BITS = 3,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [N_BITS-1:0] row_in,
    input  logic [N_BITS-1:0] col_in,
    output logic [N_BITS-1:0] row_out,
    output logic [N_BITS-1:0] col_out,
    output logic              pop_valid,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic              overflow,
`ifdef QUEEN_STACK_WATERMARK_EN
    output logic [CW-1:0]     max_depth,
`endif
    output logic              underflow
);

    logic [2*N_BITS-1:0] mem_q [DEPTH];

    logic [CW-1:0]     sp_q, sp_d;
    logic [N_BITS-1:0] row_q, row_d;
    logic [N_BITS-1:0] col_q, col_d;
    logic              pv_q, pv_d;
    logic              of_q, of_d;
    logic              uf_q, uf_d;

    logic              empty_w, full_w;
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     top_idx;

    assign empty_w = (sp_q == '0);
    assign full_w  = (sp_q == CW'(DEPTH));
    // Modular decrement of the low bits also yields DEPTH-1 when sp == DEPTH.
    assign top_idx = sp_q[AW-1:0] - AW'(1);

    always_comb begin
        sp_d   = sp_q;
        row_d  = row_q;
        col_d  = col_q;
        pv_d   = 1'b0;
        of_d   = of_q;
        uf_d   = uf_q;
        wr_en  = 1'b0;
        wr_idx = sp_q[AW-1:0];
        if (clear) begin
            sp_d  = '0;
            row_d = '0;
            col_d = '0;
            of_d  = 1'b0;
            uf_d  = 1'b0;
        end else if (pop && !empty_w) begin
            {row_d, col_d} = mem_q[top_idx];
            pv_d = 1'b1;
            if (push) begin
                // Push with pop replaces the top entry in place; depth unchanged.
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end else begin
                sp_d = sp_q - CW'(1);
            end
        end else begin
            if (pop) begin
                uf_d = 1'b1;
            end
            if (push) begin
                if (!full_w) begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + CW'(1);
                end else begin
                    of_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= {row_in, col_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            row_q <= '0;
            col_q <= '0;
            pv_q  <= 1'b0;
            of_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            row_q <= row_d;
            col_q <= col_d;
            pv_q  <= pv_d;
            of_q  <= of_d;
            uf_q  <= uf_d;
        end
    end

`ifdef QUEEN_STACK_WATERMARK_EN
    logic [CW-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (clear) begin
            max_d = '0;
        end else if (sp_q > max_q) begin
            max_d = sp_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_depth = max_q;
`endif

    assign row_out   = row_q;
    assign col_out   = col_q;
    assign pop_valid = pv_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = sp_q;
    assign overflow  = of_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_queen_stack.sv
// Self-checking bench for queen_stack against a queue-based LIFO reference model.
// Define QUEEN_STACK_WATERMARK_EN to also exercise max_depth.
module tb_queen_stack;

    localparam int unsigned NB    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [NB-1:0] row_in = '0;
    logic [NB-1:0] col_in = '0;
    logic [NB-1:0] row_out, col_out;
    logic          pop_valid, empty, full, overflow, underflow;
    logic [CW-1:0] count;
`ifdef QUEEN_STACK_WATERMARK_EN
    logic [CW-1:0] max_depth;
`endif

    queen_stack #(.N_BITS(NB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .row_in    (row_in),
        .col_in    (col_in),
        .row_out   (row_out),
        .col_out   (col_out),
        .pop_valid (pop_valid),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
`ifdef QUEEN_STACK_WATERMARK_EN
        .max_depth (max_depth),
`endif
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue used as a stack (back = top).
    logic [2*NB-1:0] stk [$];
    logic [NB-1:0]   m_row, m_col;
    logic            m_pv, m_of, m_uf;
    int              m_max;

    task automatic model_reset();
        stk.delete();
        m_row = '0; m_col = '0; m_pv = 1'b0; m_of = 1'b0; m_uf = 1'b0; m_max = 0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic clr,
                              input logic [NB-1:0] r, input logic [NB-1:0] c);
        int sz;
        sz = stk.size();
        if (clr) begin
            model_reset();
            return;
        end
        if (sz > m_max) m_max = sz;
        m_pv = 1'b0;
        if (q && sz > 0) begin
            {m_row, m_col} = stk.pop_back();
            m_pv = 1'b1;
            if (p) stk.push_back({r, c});
        end else begin
            if (q) m_uf = 1'b1;
            if (p) begin
                if (sz < DEPTH) stk.push_back({r, c});
                else m_of = 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus, let the edge happen, advance the model.
    task automatic cycle(input logic p, input logic q, input logic clr,
                         input logic [NB-1:0] r, input logic [NB-1:0] c);
        push = p; pop = q; clear = clr; row_in = r; col_in = c;
        @(posedge clk);
        #1;
        model_step(p, q, clr, r, c);
        push = 1'b0; pop = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        model_reset();
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL reset_level count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
        end
        checks++;
        if ({row_out, col_out, pop_valid, overflow, underflow} !== '0) begin
            errors++; $display("FAIL reset_outputs row=%0d col=%0d pv=%b of=%b uf=%b want all 0",
                                row_out, col_out, pop_valid, overflow, underflow);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lifo();
        logic [NB-1:0] rows [3] = '{3'd0, 3'd2, 3'd4};
        logic [NB-1:0] cols [3] = '{3'd0, 3'd1, 3'd2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, rows[i], cols[i]);
            checks++;
            if (count !== CW'(i + 1)) begin
                errors++; $display("FAIL lifo_push_count got %0d want %0d", count, i + 1);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            cycle(1'b0, 1'b1, 1'b0, '0, '0);
            checks++;
            if (row_out !== rows[i] || col_out !== cols[i] || pop_valid !== 1'b1 || count !== CW'(i)) begin
                errors++; $display("FAIL lifo_pop got (%0d,%0d) pv=%b cnt=%0d want (%0d,%0d) pv=1 cnt=%0d",
                                    row_out, col_out, pop_valid, count, rows[i], cols[i], i);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL lifo_empty got %b want 1", empty);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (pop_valid !== 1'b0 || row_out !== 3'd0 || col_out !== 3'd0) begin
            errors++; $display("FAIL lifo_idle pv=%b row=%0d col=%0d want 0,0,0", pop_valid, row_out, col_out);
        end
    endtask

    task automatic test_overflow();
        logic [2*NB-1:0] exp;
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b0, 1'b0, NB'($urandom), NB'($urandom));
        cycle(1'b1, 1'b0, 1'b0, 3'd7, 3'd7);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || count !== CW'(DEPTH)) begin
            errors++; $display("FAIL ovf_flags full=%b of=%b cnt=%0d want 1,1,%0d", full, overflow, count, DEPTH);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            exp = stk[i];
            cycle(1'b0, 1'b1, 1'b0, '0, '0);
            checks++;
            if ({row_out, col_out} !== exp || pop_valid !== 1'b1) begin
                errors++; $display("FAIL ovf_drain[%0d] got %h pv=%b want %h pv=1", i, {row_out, col_out}, pop_valid, exp);
            end
        end
        checks++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky of=%b empty=%b want 1,1", overflow, empty);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        checks++;
        if (underflow !== 1'b1 || pop_valid !== 1'b0 || row_out !== '0 || col_out !== '0 || count !== '0) begin
            errors++; $display("FAIL underflow uf=%b pv=%b row=%0d col=%0d cnt=%0d want 1,0,0,0,0",
                                underflow, pop_valid, row_out, col_out, count);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 3'd1, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd3, 3'd1);
        cycle(1'b1, 1'b1, 1'b0, 3'd5, 3'd2);
        checks++;
        if (row_out !== 3'd3 || col_out !== 3'd1 || count !== CW'(2) || pop_valid !== 1'b1) begin
            errors++; $display("FAIL pushpop got (%0d,%0d) cnt=%0d pv=%b want (3,1) cnt=2 pv=1",
                                row_out, col_out, count, pop_valid);
        end
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        checks++;
        if (row_out !== 3'd5 || col_out !== 3'd2 || count !== CW'(1)) begin
            errors++; $display("FAIL pushpop_next got (%0d,%0d) cnt=%0d want (5,2) cnt=1", row_out, col_out, count);
        end
        // Simultaneous push+pop while empty acts as push plus underflow.
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 1'b0, 3'd6, 3'd4);
        checks++;
        if (count !== CW'(1) || underflow !== 1'b1 || pop_valid !== 1'b0) begin
            errors++; $display("FAIL pushpop_empty cnt=%0d uf=%b pv=%b want 1,1,0", count, underflow, pop_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, NB'(i), NB'(i + 1));
        cycle(1'b0, 1'b1, 1'b1 == 1'b0, '0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
            pop_valid !== 1'b0 || row_out !== '0 || col_out !== '0) begin
            errors++; $display("FAIL async_reset cnt=%0d empty=%b of=%b uf=%b pv=%b row=%0d col=%0d want 0,1,0,0,0,0,0",
                                count, empty, overflow, underflow, pop_valid, row_out, col_out);
        end
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, NB'(i + 2), NB'(i));
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b1, 3'd7, 3'd7);
        checks++;
        if (count !== '0 || empty !== 1'b1 || pop_valid !== 1'b0 || row_out !== '0 || col_out !== '0) begin
            errors++; $display("FAIL clear_push cnt=%0d empty=%b pv=%b row=%0d col=%0d want 0,1,0,0,0",
                                count, empty, pop_valid, row_out, col_out);
        end
    endtask

    task automatic test_random();
        logic p, q, clr;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            p   = ($urandom_range(99) < 55);
            q   = ($urandom_range(99) < 45);
            clr = ($urandom_range(99) < 2);
            cycle(p, q, clr, NB'($urandom), NB'($urandom));
            checks++;
            if (count !== CW'(stk.size()) || empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH) ||
                row_out !== m_row || col_out !== m_col || pop_valid !== m_pv ||
                overflow !== m_of || underflow !== m_uf) begin
                errors++;
                $display("FAIL random[%0d] cnt=%0d row=%0d col=%0d pv=%b of=%b uf=%b want cnt=%0d row=%0d col=%0d pv=%b of=%b uf=%b",
                         n, count, row_out, col_out, pop_valid, overflow, underflow,
                         stk.size(), m_row, m_col, m_pv, m_of, m_uf);
            end
`ifdef QUEEN_STACK_WATERMARK_EN
            checks++;
            if (max_depth !== CW'(m_max)) begin
                errors++; $display("FAIL random_max[%0d] got %0d want %0d", n, max_depth, m_max);
            end
`endif
        end
    endtask

`ifdef QUEEN_STACK_WATERMARK_EN
    task automatic test_watermark();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, NB'(i), NB'(i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (max_depth !== CW'(5)) begin
            errors++; $display("FAIL watermark got %0d want 5", max_depth);
        end
        cycle(1'b0, 1'b0, 1'b1, '0, '0);
        checks++;
        if (max_depth !== '0) begin
            errors++; $display("FAIL watermark_clear got %0d want 0", max_depth);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_async_reset();
`ifdef QUEEN_STACK_WATERMARK_EN
        test_watermark();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
